m3_lossless_decoder: RTL and testbench
======================================

Name: m3_lossless_decoder

Overview:
- Milestone 3 stage of the image decompression pipeline: lossless decode plus dequantization.
- Sits directly upstream of the Milestone 2 IDCT unit and runs when the top-level FSM is in its Milestone 3 state, which hands it the single SRAM port.
- Reads a packed variable-length bitstream from SRAM and undoes the zigzag scan.
- Writes dequantized 16-bit signed coefficients back to SRAM, one 8x8 block at a time, for Milestone 2 to consume.

Parameters:
- BITSTREAM_BASE, 18'd0: SRAM word address of the first bitstream word.
- COEFF_BASE, 18'd76800: SRAM address of coefficient 0 of block 0.
- NUM_BLOCKS, 2400: blocks to decode (Y 1200, U 600, V 600).
- READ_LATENCY, 2: cycles from SRAM_address driven (we_n=1) until SRAM_read_data is valid.

Ports:
- CLOCK_50_I  in  1  50 MHz clock; the only clock.
- Reset  in  1  synchronous, active-high reset.
- M3_start  in  1  start request; rising edge (low->high) starts a decode.
- Q_sel  in  1  quantization table select; sampled at start.
- SRAM_read_data  in  16  SRAM controller read data.
- SRAM_address  out  18  SRAM address.
- SRAM_write_data  out  16  coefficient data.
- SRAM_we_n  out  1  active-low write enable.
- M3_done  out  1  one-cycle completion pulse.

Behaviour:
- Reset: while Reset=1 at a clock edge the block enters IDLE. SRAM_address=0, SRAM_write_data=0, SRAM_we_n=1, M3_done=0. Bit buffer, counters and in-flight reads are discarded. Reset mid-operation aborts with no further SRAM activity.
- States: IDLE -> RUN -> DONE -> IDLE.
  - IDLE -> RUN: M3_start=1 and previous-cycle M3_start=0. Q_sel is latched and the read pointer is set to BITSTREAM_BASE.
  - DONE: M3_done=1 for exactly one cycle, then IDLE.
  - Holding M3_start high does not restart a decode; it must drop low first.
- Bitstream: MSB-first within each 16-bit word, consecutive words at consecutive addresses.
  - 32-bit shift buffer with a valid-bit count.
  - At most one SRAM access per cycle.
  - A read is issued when valid + 16*outstanding <= 16. Reads have priority over writes. Read data is appended READ_LATENCY cycles after its address.
- Codes (prefix first):
  - 00 + 3-bit two's complement: one coefficient, range -4..3.
  - 01 + 6-bit two's complement: one coefficient, range -32..31.
  - 10 + 3-bit r: r zero coefficients; r=0 means 8.
  - 11: end of block; all remaining coefficients of the block are zero.
- Decode rules:
  - A code is consumed only when all of its bits are valid; otherwise decode stalls.
  - A run or EOB emits one coefficient per cycle.
  - A run crossing the 64-coefficient boundary is clipped; excess zeros are discarded.
  - EOB at index 0 zeroes the whole block.
- Zigzag: index k (0..63) maps to (row,col) by the standard JPEG zigzag, e.g. 0->(0,0), 1->(0,1), 2->(1,0), 3->(2,0), 4->(1,1), 8->(2,1), 63->(7,7).
- Dequantization: out = sign-extended value << s, as a 16-bit signed result. s is indexed by d = row+col:
  - Q_sel=0: d=0 ->3, d=1 ->2, d=2..3 ->3, d=4..5 ->4, d=6..7 ->5, d>=8 ->6.
  - Q_sel=1: d=0 ->3, d=1 ->1, d=2..3 ->1, d=4..5 ->2, d=6..7 ->2, d>=8 ->3.
  - The result never exceeds 16 bits; no saturation.
- Write path:
  - Write address = COEFF_BASE + block*64 + row*8 + col.
  - A one-entry write holding register feeds the port; the decoder advances only when the register is empty or is being written this cycle.
  - A write blocked by a read stays pending unchanged.
- Completion:
  - After the 64*NUM_BLOCKS-th write completes, go to DONE.
  - Unconsumed bitstream bits and reads still in flight are ignored; their returning data is dropped.
- SRAM_we_n=0 only in a cycle carrying a valid write. In all non-RUN states SRAM_we_n=1.

Test Plan:
- NUM_BLOCKS=2, stream word 0xF000 (two EOBs), start pulse -> 128 writes of 0x0000 to 76800..76927, each address exactly once, then one M3_done pulse.
- NUM_BLOCKS=1, Q_sel=0, stream 0x1E00 (00 011, EOB) -> 76800=0x0018 (24), 76801..76863=0, done pulse.
- NUM_BLOCKS=1, Q_sel=0, stream 0x0306 (00 000, 01 100000, EOB) -> 76800=0x0000, 76801=0xFF80 (-128).
- Stream 10 000, 00 001, 11 -> 8 zeros then index 8 (2,1) -> 76817=0x0008 with Q_sel=0, and 0x0002 with Q_sel=1; all other addresses 0.
- Long random stream checked against a reference model. Read addresses are consecutive from 0, no cycle has both a read and a write, and a stalled write holds its address and data.
- Reset asserted mid-block -> next cycle we_n=1, done=0. M3_start held high after done -> no restart; a new low->high edge decodes the stream again from BITSTREAM_BASE.

Source files
------------

// File: rtl/m3_lossless_decoder.sv
// Milestone 3: variable-length bitstream decode, zigzag reorder and dequantization.
// Streams 16-bit signed coefficients back to SRAM one 8x8 block at a time.
module m3_lossless_decoder #(
  parameter logic [17:0] BITSTREAM_BASE = 18'd0,
  parameter logic [17:0] COEFF_BASE     = 18'd76800,
  parameter int unsigned NUM_BLOCKS     = 2400,
  parameter int unsigned READ_LATENCY   = 2
) (
  input  logic        CLOCK_50_I,
  input  logic        Reset,
  input  logic        M3_start,
  input  logic        Q_sel,
  input  logic [15:0] SRAM_read_data,
  output logic [17:0] SRAM_address,
  output logic [15:0] SRAM_write_data,
  output logic        SRAM_we_n,
  output logic        M3_done
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  localparam int unsigned BLK_W = $clog2(NUM_BLOCKS + 1);

  logic [1:0]              state_q, state_d;
  logic                    start_prev_q;
  logic                    q_sel_q, q_sel_d;
  logic [31:0]             bit_buf_q, bit_buf_d;
  logic [5:0]              bit_cnt_q, bit_cnt_d;
  logic [READ_LATENCY:0]   rd_pipe_q, rd_pipe_d;
  logic [17:0]             rd_ptr_q, rd_ptr_d;
  logic [2:0]              row_q, row_d, col_q, col_d;
  logic [3:0]              run_q, run_d;
  logic                    eob_q, eob_d;
  logic [BLK_W-1:0]        blk_q, blk_d;
  logic [17:0]             blk_base_q, blk_base_d;
  logic                    wr_valid_q, wr_valid_d;
  logic [17:0]             wr_addr_q, wr_addr_d;
  logic [15:0]             wr_data_q, wr_data_d;

  logic                    start_edge, arrive, wr_fire, wr_free, emit;
  logic [5:0]              consumed, cnt_left;
  logic [31:0]             buf_left;
  logic [15:0]             coef;
  int unsigned             outs;

  function automatic logic [2:0] deq_shift(input logic qs, input logic [3:0] d);
    if (!qs) begin
      if (d == 4'd0)      return 3'd3;
      else if (d == 4'd1) return 3'd2;
      else if (d <= 4'd3) return 3'd3;
      else if (d <= 4'd5) return 3'd4;
      else if (d <= 4'd7) return 3'd5;
      else                return 3'd6;
    end else begin
      if (d == 4'd0)      return 3'd3;
      else if (d <= 4'd3) return 3'd1;
      else if (d <= 4'd7) return 3'd2;
      else                return 3'd3;
    end
  endfunction

  // A read owns the port in its address cycle; otherwise a pending write goes out.
  assign wr_fire         = (state_q == S_RUN) && wr_valid_q && !rd_pipe_q[0];
  assign SRAM_we_n       = !wr_fire;
  assign SRAM_address    = wr_fire ? wr_addr_q : rd_ptr_q;
  assign SRAM_write_data = wr_data_q;
  assign M3_done         = (state_q == S_DONE);

  always_comb begin
    state_d    = state_q;
    q_sel_d    = q_sel_q;
    bit_buf_d  = bit_buf_q;
    bit_cnt_d  = bit_cnt_q;
    rd_pipe_d  = {rd_pipe_q[READ_LATENCY-1:0], 1'b0};
    rd_ptr_d   = rd_ptr_q;
    row_d      = row_q;
    col_d      = col_q;
    run_d      = run_q;
    eob_d      = eob_q;
    blk_d      = blk_q;
    blk_base_d = blk_base_q;
    wr_valid_d = wr_valid_q;
    wr_addr_d  = wr_addr_q;
    wr_data_d  = wr_data_q;
    emit       = 1'b0;
    coef       = 16'd0;
    consumed   = 6'd0;
    outs       = 0;

    start_edge = M3_start && !start_prev_q;
    arrive     = (state_q == S_RUN) && rd_pipe_q[READ_LATENCY];
    wr_free    = !wr_valid_q || wr_fire;

    if ((state_q == S_RUN) && (blk_q != BLK_W'(NUM_BLOCKS)) && wr_free) begin
      if (eob_q || (run_q != 4'd0)) begin
        emit = 1'b1;
        if (run_q != 4'd0) run_d = run_q - 4'd1;
      end else if (bit_cnt_q >= 6'd2) begin
        case (bit_buf_q[31:30])
          2'b00: if (bit_cnt_q >= 6'd5) begin
            emit     = 1'b1;
            consumed = 6'd5;
            coef     = {{13{bit_buf_q[29]}}, bit_buf_q[29:27]};
          end
          2'b01: if (bit_cnt_q >= 6'd8) begin
            emit     = 1'b1;
            consumed = 6'd8;
            coef     = {{10{bit_buf_q[29]}}, bit_buf_q[29:24]};
          end
          2'b10: if (bit_cnt_q >= 6'd5) begin
            // First zero of the run goes out now; the rest count down.
            emit     = 1'b1;
            consumed = 6'd5;
            run_d    = (bit_buf_q[29:27] == 3'd0) ? 4'd7 : ({1'b0, bit_buf_q[29:27]} - 4'd1);
          end
          default: begin
            emit     = 1'b1;
            consumed = 6'd2;
            eob_d    = 1'b1;
          end
        endcase
      end
    end

    if (emit) begin
      wr_valid_d = 1'b1;
      wr_addr_d  = blk_base_q + {12'd0, row_q, col_q};
      wr_data_d  = coef << deq_shift(q_sel_q, {1'b0, row_q} + {1'b0, col_q});
      if ((row_q == 3'd7) && (col_q == 3'd7)) begin
        row_d      = 3'd0;
        col_d      = 3'd0;
        run_d      = 4'd0;
        eob_d      = 1'b0;
        blk_d      = blk_q + BLK_W'(1);
        blk_base_d = blk_base_q + 18'd64;
      end else if (!(row_q[0] ^ col_q[0])) begin
        if (col_q == 3'd7) row_d = row_q + 3'd1;
        else if (row_q == 3'd0) col_d = col_q + 3'd1;
        else begin
          row_d = row_q - 3'd1;
          col_d = col_q + 3'd1;
        end
      end else begin
        if (row_q == 3'd7) col_d = col_q + 3'd1;
        else if (col_q == 3'd0) row_d = row_q + 3'd1;
        else begin
          row_d = row_q + 3'd1;
          col_d = col_q - 3'd1;
        end
      end
    end else if (wr_fire) begin
      wr_valid_d = 1'b0;
    end

    // Valid bits stay left-aligned; a returning word lands right after them.
    cnt_left = bit_cnt_q - consumed;
    buf_left = bit_buf_q << consumed;
    if (arrive) begin
      bit_buf_d = buf_left | ({SRAM_read_data, 16'h0000} >> cnt_left);
      bit_cnt_d = cnt_left + 6'd16;
    end else begin
      bit_buf_d = buf_left;
      bit_cnt_d = cnt_left;
    end
    if ((state_q == S_RUN) && rd_pipe_q[0]) rd_ptr_d = rd_ptr_q + 18'd1;

    case (state_q)
      S_IDLE: if (start_edge) begin
        state_d    = S_RUN;
        q_sel_d    = Q_sel;
        rd_ptr_d   = BITSTREAM_BASE;
        bit_buf_d  = 32'd0;
        bit_cnt_d  = 6'd0;
        row_d      = 3'd0;
        col_d      = 3'd0;
        run_d      = 4'd0;
        eob_d      = 1'b0;
        blk_d      = '0;
        blk_base_d = COEFF_BASE;
        wr_valid_d = 1'b0;
      end
      S_RUN: if ((blk_q == BLK_W'(NUM_BLOCKS)) && !wr_valid_q) state_d = S_DONE;
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    if (state_d != S_RUN) begin
      rd_pipe_d = '0;
    end else begin
      for (int i = 1; i <= int'(READ_LATENCY); i++) outs = outs + 32'(rd_pipe_d[i]);
      if (({26'd0, bit_cnt_d} + (outs << 4)) <= 32'd16) rd_pipe_d[0] = 1'b1;
    end
  end

  always_ff @(posedge CLOCK_50_I) begin
    start_prev_q <= M3_start;
    if (Reset) begin
      state_q    <= S_IDLE;
      q_sel_q    <= 1'b0;
      bit_buf_q  <= 32'd0;
      bit_cnt_q  <= 6'd0;
      rd_pipe_q  <= '0;
      rd_ptr_q   <= 18'd0;
      row_q      <= 3'd0;
      col_q      <= 3'd0;
      run_q      <= 4'd0;
      eob_q      <= 1'b0;
      blk_q      <= '0;
      blk_base_q <= COEFF_BASE;
      wr_valid_q <= 1'b0;
      wr_addr_q  <= 18'd0;
      wr_data_q  <= 16'd0;
    end else begin
      state_q    <= state_d;
      q_sel_q    <= q_sel_d;
      bit_buf_q  <= bit_buf_d;
      bit_cnt_q  <= bit_cnt_d;
      rd_pipe_q  <= rd_pipe_d;
      rd_ptr_q   <= rd_ptr_d;
      row_q      <= row_d;
      col_q      <= col_d;
      run_q      <= run_d;
      eob_q      <= eob_d;
      blk_q      <= blk_d;
      blk_base_q <= blk_base_d;
      wr_valid_q <= wr_valid_d;
      wr_addr_q  <= wr_addr_d;
      wr_data_q  <= wr_data_d;
    end
  end

endmodule

// File: tb/tb_m3_lossless_decoder.sv
// Scoreboard bench for m3_lossless_decoder: a code-level reference model predicts the write
// sequence, a negedge monitor compares every SRAM write and watches read-address order.
module tb_m3_lossless_decoder;

  localparam int unsigned NB = 3;
  localparam logic [17:0] CB = 18'd76800;

  logic        CLOCK_50_I = 1'b0;
  logic        Reset, M3_start, Q_sel;
  logic [15:0] SRAM_read_data;
  logic [17:0] SRAM_address;
  logic [15:0] SRAM_write_data;
  logic        SRAM_we_n, M3_done;

  always #10 CLOCK_50_I = ~CLOCK_50_I;

  m3_lossless_decoder #(
    .BITSTREAM_BASE(18'd0),
    .COEFF_BASE    (CB),
    .NUM_BLOCKS    (NB),
    .READ_LATENCY  (2)
  ) dut (
    .CLOCK_50_I     (CLOCK_50_I),
    .Reset          (Reset),
    .M3_start       (M3_start),
    .Q_sel          (Q_sel),
    .SRAM_read_data (SRAM_read_data),
    .SRAM_address   (SRAM_address),
    .SRAM_write_data(SRAM_write_data),
    .SRAM_we_n      (SRAM_we_n),
    .M3_done        (M3_done)
  );

  // SRAM read port: data for the address of cycle t is presented in cycle t+2.
  logic [15:0] stream_mem [0:255];
  logic [17:0] a1 = '0, a2 = '0;
  always @(posedge CLOCK_50_I) begin
    a1 <= SRAM_address;
    a2 <= a1;
  end
  always_comb SRAM_read_data = (a2 < 18'd256) ? stream_mem[a2[7:0]] : 16'hFFFF;

  int          checks = 0, passed = 0;
  bit          bits[$];
  logic [17:0] exp_addr[$];
  logic [15:0] exp_data[$];
  int          zz_r[64], zz_c[64];
  int          sh_tab[2][15];
  logic [15:0] cmem [0:NB*64-1];
  int          wr_cnt = 0, done_cnt = 0, rd_err = 0;
  bit          run_active = 0, first_rd = 0, prev_done = 0;
  logic [17:0] last_rd = '0;

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got === exp) passed++;
    else $display("FAIL %s: got %h expected %h", nm, got, exp);
  endtask

  task automatic add_code(input int val, input int len);
    for (int i = len - 1; i >= 0; i--) bits.push_back(bit'((val >> i) & 1));
  endtask

  task automatic load_stream();
    for (int w = 0; w < 256; w++) begin
      logic [15:0] word;
      word = '0;
      for (int j = 0; j < 16; j++)
        if (w * 16 + j < bits.size()) word[15-j] = bits[w*16+j];
      stream_mem[w] = word;
    end
  endtask

  function automatic int getb(input int p, input int n);
    int v;
    v = 0;
    for (int i = 0; i < n; i++) v = v * 2 + ((p + i < bits.size()) ? int'(bits[p+i]) : 0);
    return v;
  endfunction

  // Parse codes straight from the bit list and produce every write in decode order.
  task automatic model(input bit qs);
    int pos;
    pos = 0;
    for (int b = 0; b < int'(NB); b++) begin
      int c[64];
      int k;
      for (int i = 0; i < 64; i++) c[i] = 0;
      k = 0;
      while (k < 64) begin
        int pre, v;
        pre = getb(pos, 2);
        pos += 2;
        if (pre == 0) begin
          v = getb(pos, 3); pos += 3;
          if (v >= 4) v -= 8;
          c[k] = v; k++;
        end else if (pre == 1) begin
          v = getb(pos, 6); pos += 6;
          if (v >= 32) v -= 64;
          c[k] = v; k++;
        end else if (pre == 2) begin
          v = getb(pos, 3); pos += 3;
          k += (v == 0) ? 8 : v;
        end else begin
          k = 64;
        end
      end
      for (int j = 0; j < 64; j++) begin
        exp_addr.push_back(CB + 18'(b * 64 + zz_r[j] * 8 + zz_c[j]));
        exp_data.push_back(16'(c[j] * (1 << sh_tab[qs][zz_r[j] + zz_c[j]])));
      end
    end
  endtask

  task automatic rand_stream();
    bits.delete();
    repeat (400) begin
      int x;
      x = $urandom_range(0, 99);
      if (x < 40) begin add_code(0, 2); add_code($urandom_range(0, 7), 3); end
      else if (x < 75) begin add_code(1, 2); add_code($urandom_range(0, 63), 6); end
      else if (x < 95) begin add_code(2, 2); add_code($urandom_range(0, 7), 3); end
      else add_code(3, 2);
    end
    load_stream();
  endtask

  task automatic run_decode(input bit qs, input bit hold, input string nm);
    int d0, w0;
    d0 = done_cnt;
    w0 = wr_cnt;
    for (int i = 0; i < int'(NB) * 64; i++) cmem[i] = 16'hDEAD;
    exp_addr.delete();
    exp_data.delete();
    model(qs);
    rd_err = 0;
    @(posedge CLOCK_50_I); #1 M3_start = 1'b0;
    @(posedge CLOCK_50_I); #1 M3_start = 1'b1; Q_sel = qs;
    @(posedge CLOCK_50_I); #1 run_active = 1'b1; first_rd = 1'b1; Q_sel = ~qs;
    if (!hold) M3_start = 1'b0;
    for (int i = 0; i < 4000 && done_cnt == d0; i++) @(negedge CLOCK_50_I);
    repeat (5) @(negedge CLOCK_50_I);
    chk({nm, "_done"}, 64'(done_cnt - d0), 64'd1);
    chk({nm, "_writes"}, 64'(wr_cnt - w0), 64'(NB * 64));
    chk({nm, "_pending"}, 64'(exp_addr.size()), 64'd0);
    chk({nm, "_rd_seq"}, 64'(rd_err), 64'd0);
  endtask

  // Monitor: every write is popped against the scoreboard; reads must step by at most one.
  initial begin
    forever begin
      @(negedge CLOCK_50_I);
      if (Reset) begin
        prev_done = 1'b0;
      end else begin
        if (!SRAM_we_n) begin
          wr_cnt++;
          if (exp_addr.size() == 0) begin
            checks++;
            $display("FAIL extra_write: got addr %0d data %h, none expected", SRAM_address,
                     SRAM_write_data);
          end else begin
            logic [17:0] ea;
            logic [15:0] ed;
            ea = exp_addr.pop_front();
            ed = exp_data.pop_front();
            chk("write", {30'd0, SRAM_address, SRAM_write_data}, {30'd0, ea, ed});
          end
          if (SRAM_address >= CB && SRAM_address < CB + 18'(NB * 64))
            cmem[int'(SRAM_address - CB)] = SRAM_write_data;
        end else if (run_active) begin
          if (first_rd) begin
            if (SRAM_address != 18'd0) rd_err++;
            first_rd = 1'b0;
          end else if (SRAM_address != last_rd && SRAM_address != last_rd + 18'd1) begin
            rd_err++;
          end
          last_rd = SRAM_address;
        end
        if (M3_done) begin
          chk("done_one_cycle", 64'(prev_done), 64'd0);
          done_cnt++;
          run_active = 1'b0;
        end
        prev_done = M3_done;
      end
    end
  end

  initial begin
    int k, w0, d0;
    sh_tab[0] = '{3, 2, 3, 3, 4, 4, 5, 5, 6, 6, 6, 6, 6, 6, 6};
    sh_tab[1] = '{3, 1, 1, 1, 2, 2, 2, 2, 3, 3, 3, 3, 3, 3, 3};
    k = 0;
    for (int d = 0; d < 15; d++) begin
      int lo, hi;
      lo = (d > 7) ? d - 7 : 0;
      hi = (d < 7) ? d : 7;
      if (d % 2 == 0) for (int r = hi; r >= lo; r--) begin zz_r[k] = r; zz_c[k] = d - r; k++; end
      else for (int r = lo; r <= hi; r++) begin zz_r[k] = r; zz_c[k] = d - r; k++; end
    end
    bits.delete();
    load_stream();

    Reset = 1'b1; M3_start = 1'b0; Q_sel = 1'b0;
    repeat (3) @(posedge CLOCK_50_I);
    @(negedge CLOCK_50_I);
    chk("rst_we_n", 64'(SRAM_we_n), 64'd1);
    chk("rst_done", 64'(M3_done), 64'd0);
    chk("rst_addr", 64'(SRAM_address), 64'd0);
    chk("rst_wdata", 64'(SRAM_write_data), 64'd0);
    @(posedge CLOCK_50_I); #1 Reset = 1'b0;

    // All-EOB blocks
    bits.delete(); repeat (NB) add_code(3, 2); load_stream();
    run_decode(1'b0, 1'b0, "eob");
    chk("eob_last", 64'(cmem[NB*64-1]), 64'd0);

    bits.delete(); add_code(0, 2); add_code(3, 3); repeat (NB) add_code(3, 2); load_stream();
    run_decode(1'b0, 1'b0, "dc3");
    chk("dc3_c0", 64'(cmem[0]), 64'h0018);
    chk("dc3_c1", 64'(cmem[1]), 64'h0000);

    bits.delete(); add_code(0, 2); add_code(0, 3); add_code(1, 2); add_code(32, 6);
    repeat (NB) add_code(3, 2); load_stream();
    run_decode(1'b0, 1'b0, "neg");
    chk("neg_c0", 64'(cmem[0]), 64'h0000);
    chk("neg_c1", 64'(cmem[1]), 64'hFF80);

    bits.delete(); add_code(2, 2); add_code(0, 3); add_code(0, 2); add_code(1, 3);
    repeat (NB) add_code(3, 2); load_stream();
    run_decode(1'b0, 1'b0, "run8_q0");
    chk("run8_q0_c17", 64'(cmem[17]), 64'h0008);
    chk("run8_q0_c16", 64'(cmem[16]), 64'h0000);
    run_decode(1'b1, 1'b0, "run8_q1");
    chk("run8_q1_c17", 64'(cmem[17]), 64'h0002);

    for (int r = 0; r < 4; r++) begin
      rand_stream();
      run_decode(bit'($urandom_range(0, 1)), 1'b0, $sformatf("rand%0d", r));
    end

    // Reset in the middle of a block
    rand_stream();
    exp_addr.delete(); exp_data.delete(); model(1'b0);
    @(posedge CLOCK_50_I); #1 M3_start = 1'b1; Q_sel = 1'b0;
    @(posedge CLOCK_50_I); #1 run_active = 1'b1; first_rd = 1'b1; M3_start = 1'b0;
    repeat (60) @(posedge CLOCK_50_I);
    #1 Reset = 1'b1; run_active = 1'b0;
    @(posedge CLOCK_50_I);
    @(negedge CLOCK_50_I);
    chk("midrst_we_n", 64'(SRAM_we_n), 64'd1);
    chk("midrst_done", 64'(M3_done), 64'd0);
    @(posedge CLOCK_50_I); #1 Reset = 1'b0;
    exp_addr.delete(); exp_data.delete();
    w0 = wr_cnt; d0 = done_cnt;
    repeat (20) @(negedge CLOCK_50_I);
    chk("midrst_quiet_wr", 64'(wr_cnt - w0), 64'd0);
    chk("midrst_quiet_done", 64'(done_cnt - d0), 64'd0);

    // Start held high after completion must not retrigger
    rand_stream();
    run_decode(1'b1, 1'b1, "hold");
    w0 = wr_cnt; d0 = done_cnt;
    repeat (40) @(negedge CLOCK_50_I);
    chk("hold_no_wr", 64'(wr_cnt - w0), 64'd0);
    chk("hold_no_done", 64'(done_cnt - d0), 64'd0);
    run_decode(1'b1, 1'b0, "restart");

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
